ldst_unit: RTL and testbench

- Data-memory access stage directly downstream of the instruction decoder.
- Consumes the decoder's 3-bit load/store control code plus the ALU-computed effective address and rt store data.
- Generates word-aligned data-memory requests with byte enables, and returns sign- or zero-extended load results to writeback.
- Stalls the pipeline through `busy` while a request is in flight.

---
 rtl/ldst_unit.sv | 192 +++++++++++++++++++
 tb/tb_ldst_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_unit.sv
// Load/store unit: turns decoded memory ops into word-aligned data-memory requests and returns
// extended load results. Optional request timeout is enabled by defining LDST_TIMEOUT_EN.
module ldst_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [2:0]            ld_st_ctrl,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  misaligned,
  output logic                  timeout,
  output logic                  dmem_req,
  output logic [3:0]            dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [31:0]           dmem_rdata
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t     state;
  logic [2:0] ctrl_p1;
  logic [1:0] lane_p1;
  logic       misalign_p0;
  logic [3:0] we_p0;
  logic [31:0] wdata_p0;

  function automatic logic is_store(input logic [2:0] ctrl);
    return (ctrl == OP_SB) || (ctrl == OP_SH) || (ctrl == OP_SW);
  endfunction

  function automatic logic check_misalign(input logic [2:0] ctrl, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (ctrl)
      OP_LH, OP_LHU, OP_SH: bad = lane[0];
      OP_LW, OP_SW:         bad = |lane;
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Picks the addressed byte/half out of the read word and extends it to 32 bits.
  function automatic logic [31:0] extract(input logic [2:0] ctrl, input logic [1:0] lane,
                                          input logic [31:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        res;
    byte_s = word[{lane, 3'b000} +: 8];
    half_s = lane[1] ? word[31:16] : word[15:0];
    case (ctrl)
      OP_LB:   res = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  res = {24'd0, byte_s};
      OP_LH:   res = {{16{half_s[15]}}, half_s};
      OP_LHU:  res = {16'd0, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

  // Acceptance-cycle decode: alignment, byte enables and lane-replicated store data.
  always_comb begin
    misalign_p0 = check_misalign(ld_st_ctrl, addr[1:0]);
    we_p0       = 4'b0000;
    wdata_p0    = store_data;
    case (ld_st_ctrl)
      OP_SB: begin
        we_p0    = 4'b0001 << addr[1:0];
        wdata_p0 = {4{store_data[7:0]}};
      end
      OP_SH: begin
        we_p0    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_p0 = {2{store_data[15:0]}};
      end
      OP_SW: begin
        we_p0    = 4'b1111;
        wdata_p0 = store_data;
      end
      default: begin
        we_p0    = 4'b0000;
        wdata_p0 = store_data;
      end
    endcase
  end

`ifdef LDST_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      ctrl_p1    <= 3'd0;
      lane_p1    <= 2'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 4'd0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'd0;
`ifdef LDST_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      load_valid <= 1'b0;
      misaligned <= 1'b0;
`ifdef LDST_TIMEOUT_EN
      timeout    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misalign_p0) begin
              misaligned <= 1'b1;
            end else begin
              state      <= REQ;
              busy       <= 1'b1;
              dmem_req   <= 1'b1;
              ctrl_p1    <= ld_st_ctrl;
              lane_p1    <= addr[1:0];
              dmem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              dmem_we    <= we_p0;
              dmem_wdata <= wdata_p0;
`ifdef LDST_TIMEOUT_EN
              wait_cnt   <= '0;
`endif
            end
          end
        end
        // Request in flight; an ack in the final allowed cycle still completes normally.
        REQ: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (is_store(ctrl_p1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              load_data  <= extract(ctrl_p1, lane_p1, dmem_rdata);
              load_valid <= 1'b1;
              state      <= RESP;
            end
          end
`ifdef LDST_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            dmem_req <= 1'b0;
            timeout  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldst_unit.sv
// Scoreboard bench for ldst_unit: stimulus pushes expected memory/load/pulse events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ldst_unit;

  localparam int AW = 32;
  localparam int MW = 4;

  localparam int K_MEM  = 0;
  localparam int K_LOAD = 1;
  localparam int K_MIS  = 2;
  localparam int K_TMO  = 3;

  // op kinds for the stimulus task
  localparam int OK_STORE = 0;
  localparam int OK_LOAD  = 1;
  localparam int OK_MIS   = 2;
  localparam int OK_TMO   = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    bit          chk_c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [2:0]    ld_st_ctrl;
  logic [AW-1:0] addr;
  logic [31:0]   store_data;
  logic          busy;
  logic [31:0]   load_data;
  logic          load_valid;
  logic          misaligned;
  logic          timeout;
  logic          dmem_req;
  logic [3:0]    dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          dmem_ack;
  logic [31:0]   dmem_rdata;

  exp_t q[$];
  int   nchk  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  ldst_unit #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .ld_st_ctrl (ld_st_ctrl),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misaligned (misaligned),
    .timeout    (timeout),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input bit chk_c);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c; e.chk_c = chk_c;
    q.push_back(e);
  endtask

  task automatic mon(input string name, input int kind, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c);
    exp_t e;
    nchk++;
    if (q.size() == 0) begin
      nfail++;
      $display("FAIL %s: unexpected event a=%h b=%h c=%h, none expected", name, a, b, c);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || a !== e.a || b !== e.b || (e.chk_c && c !== e.c)) begin
        nfail++;
        $display("FAIL %s: got kind=%0d a=%h b=%h c=%h expected kind=%0d a=%h b=%h c=%h",
                 name, kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (dmem_req && dmem_ack) mon("mem_req", K_MEM, dmem_addr, {28'd0, dmem_we}, dmem_wdata);
      if (load_valid)           mon("load", K_LOAD, load_data, 32'd0, 32'd0);
      if (misaligned)           mon("misaligned", K_MIS, 32'd0, 32'd0, 32'd0);
      if (timeout)              mon("timeout", K_TMO, 32'd0, 32'd0, 32'd0);
    end
  end

  // Issues one op starting #1 after a clock edge; returns #1 after the edge where state is IDLE.
  task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] sd,
                    input logic [31:0] rd, input int dly, input int kind,
                    input logic [3:0] exp_we, input logic [31:0] exp_wd,
                    input logic [31:0] exp_ld);
    case (kind)
      OK_MIS:   push(K_MIS, 32'd0, 32'd0, 32'd0, 1'b0);
      OK_TMO:   push(K_TMO, 32'd0, 32'd0, 32'd0, 1'b0);
      OK_STORE: push(K_MEM, {a[31:2], 2'b00}, {28'd0, exp_we}, exp_wd, 1'b1);
      default: begin
        push(K_MEM, {a[31:2], 2'b00}, {28'd0, exp_we}, 32'd0, 1'b0);
        push(K_LOAD, exp_ld, 32'd0, 32'd0, 1'b0);
      end
    endcase
    req_valid = 1'b1; ld_st_ctrl = c; addr = a; store_data = sd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (kind == OK_MIS) begin
      check_eq("mis_busy", {31'd0, busy}, 32'd0);
      check_eq("mis_dmem_req", {31'd0, dmem_req}, 32'd0);
      return;
    end
    for (int i = 0; i <= dly; i++) begin
      check_eq("req_busy", {31'd0, busy}, 32'd1);
      check_eq("req_dmem_req", {31'd0, dmem_req}, 32'd1);
      dmem_ack   = (kind != OK_TMO) && (i == dly);
      dmem_rdata = rd;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    check_eq("after_req_dmem_req", {31'd0, dmem_req}, 32'd0);
    if (kind == OK_LOAD) begin
      check_eq("resp_busy", {31'd0, busy}, 32'd1);
      check_eq("load_valid_latency", {31'd0, load_valid}, 32'd1);
      @(posedge clk); #1;
      check_eq("load_valid_once", {31'd0, load_valid}, 32'd0);
    end
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; ld_st_ctrl = 3'd0; addr = '0; store_data = 32'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check_eq("rst_outs", {dmem_we, 1'b0, load_valid, misaligned, timeout}, 8'd0);
    check_eq("rst_dmem_addr", dmem_addr, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // stores (back-to-back acceptance after each ack)
    op(3'b111, 32'h100, 32'hDEADBEEF, 32'h0, 0, OK_STORE, 4'b1111, 32'hDEADBEEF, 32'h0);
    op(3'b101, 32'h203, 32'h000000A5, 32'h0, 0, OK_STORE, 4'b1000, 32'hA5A5A5A5, 32'h0);
    op(3'b101, 32'h201, 32'h12345677, 32'h0, 0, OK_STORE, 4'b0010, 32'h77777777, 32'h0);
    op(3'b110, 32'h502, 32'h1234ABCD, 32'h0, 0, OK_STORE, 4'b1100, 32'hABCDABCD, 32'h0);
    op(3'b110, 32'h500, 32'h1234ABCD, 32'h0, 0, OK_STORE, 4'b0011, 32'hABCDABCD, 32'h0);

    // loads
    op(3'b000, 32'h301, 32'h0, 32'h1234F600, 0, OK_LOAD, 4'b0000, 32'h0, 32'hFFFFFFF6);
    op(3'b011, 32'h301, 32'h0, 32'h1234F600, 0, OK_LOAD, 4'b0000, 32'h0, 32'h000000F6);
    op(3'b000, 32'h303, 32'h0, 32'h1234F600, 0, OK_LOAD, 4'b0000, 32'h0, 32'h00000012);
    op(3'b001, 32'h402, 32'h0, 32'h80017FFF, 0, OK_LOAD, 4'b0000, 32'h0, 32'hFFFF8001);
    op(3'b100, 32'h402, 32'h0, 32'h80017FFF, 0, OK_LOAD, 4'b0000, 32'h0, 32'h00008001);
    op(3'b001, 32'h400, 32'h0, 32'h80017FFF, 0, OK_LOAD, 4'b0000, 32'h0, 32'h00007FFF);
    op(3'b010, 32'h504, 32'h0, 32'hCAFEF00D, 0, OK_LOAD, 4'b0000, 32'h0, 32'hCAFEF00D);

    // misaligned rejections
    op(3'b010, 32'h502, 32'h0, 32'h0, 0, OK_MIS, 4'b0000, 32'h0, 32'h0);
    op(3'b110, 32'h501, 32'h0, 32'h0, 0, OK_MIS, 4'b0000, 32'h0, 32'h0);
    op(3'b100, 32'h403, 32'h0, 32'h0, 0, OK_MIS, 4'b0000, 32'h0, 32'h0);
    op(3'b111, 32'h10A, 32'h0, 32'h0, 0, OK_MIS, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_eq("mis_pulse_once", {31'd0, misaligned}, 32'd0);

`ifdef LDST_TIMEOUT_EN
    // ack in the last allowed cycle wins, then no ack at all times out
    op(3'b010, 32'h700, 32'h0, 32'h0BADF00D, MW - 1, OK_LOAD, 4'b0000, 32'h0, 32'h0BADF00D);
    op(3'b010, 32'h704, 32'h0, 32'h0, MW - 1, OK_TMO, 4'b0000, 32'h0, 32'h0);
    check_eq("tmo_load_valid", {31'd0, load_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("tmo_pulse_once", {31'd0, timeout}, 32'd0);
`else
    op(3'b010, 32'h700, 32'h0, 32'h0BADF00D, 5, OK_LOAD, 4'b0000, 32'h0, 32'h0BADF00D);
    check_eq("no_timeout", {31'd0, timeout}, 32'd0);
`endif

    // reset in the middle of a request
    req_valid = 1'b1; ld_st_ctrl = 3'b010; addr = 32'h600; store_data = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check_eq("midrst_load_data", load_data, 32'd0);
    check_eq("midrst_flags", {dmem_we, 1'b0, load_valid, misaligned, timeout}, 8'd0);
    check_eq("midrst_dmem_addr", dmem_addr, 32'd0);
    check_eq("midrst_wdata", dmem_wdata, 32'd0);
    dmem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    check_eq("post_rst_idle", {31'd0, busy}, 32'd0);

    op(3'b111, 32'h80C, 32'h01020304, 32'h0, 0, OK_STORE, 4'b1111, 32'h01020304, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("scoreboard_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
